// File: rtl/red_pitaya_trigger_log_pkg.sv
// Shared register map and address decode for the trigger timestamp log.
// The PS driver and the bench use these same offsets.
package red_pitaya_trigger_log_pkg;

  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_TS_LO  = 16'h0008;
  localparam logic [15:0] ADDR_TS_HI  = 16'h000C;
  localparam logic [15:0] ADDR_PHASE  = 16'h0010;
  localparam logic [15:0] ADDR_DEPTH  = 16'h0014;

  localparam int TSBITS_DFLT    = 64;
  localparam int PHASEBITS_DFLT = 14;
  localparam int ENTRY_W_DFLT   = TSBITS_DFLT + PHASEBITS_DFLT;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_TS_LO,
    SEL_TS_HI,
    SEL_PHASE,
    SEL_DEPTH,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [15:0] a);
    reg_sel_e s;
    case (a)
      ADDR_CTRL:   s = SEL_CTRL;
      ADDR_STATUS: s = SEL_STATUS;
      ADDR_TS_LO:  s = SEL_TS_LO;
      ADDR_TS_HI:  s = SEL_TS_HI;
      ADDR_PHASE:  s = SEL_PHASE;
      ADDR_DEPTH:  s = SEL_DEPTH;
      default:     s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/red_pitaya_trigger_log_fifo.sv
// Register-array FIFO with a combinational head; full/empty derive from an
// explicit occupancy count so pointer wrap never aliases full with empty.
module red_pitaya_trigger_log_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 78
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_nxt,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;

  assign head  = mem[rptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PTR_ONE;
        if (pop)  rptr <= rptr + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push && !flush)
      mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/red_pitaya_trigger_log.sv
// Trigger event log: captures {timestamp, phase} on each trigger into a FIFO
// drained over the sys-bus; overflow is counted and empty reads are flagged.
module red_pitaya_trigger_log
  import red_pitaya_trigger_log_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int TSBITS     = 64,
  parameter int PHASEBITS  = 14
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 trig_i,
  input  logic [TSBITS-1:0]    ts_i,
  input  logic [PHASEBITS-1:0] phase_i,
  output logic                 not_empty_o,
  input  logic [15:0]          addr,
  input  logic                 wen,
  input  logic                 ren,
  output logic                 ack,
  output logic [31:0]          rdata,
  input  logic [31:0]          wdata
);

  localparam int ENTRY_W = TSBITS + PHASEBITS;

  logic                 enable;
  logic                 underflow;
  logic [15:0]          ovf_cnt;
  logic [TSBITS-33:0]   shadow_hi;
  logic [PHASEBITS-1:0] shadow_phase;

  logic [ENTRY_W-1:0]   head;
  logic [TSBITS-1:0]    head_ts;
  logic [PHASEBITS-1:0] head_phase;
  logic [DEPTH_LOG2:0]  count;
  logic [DEPTH_LOG2:0]  count_nxt;
  logic                 full;
  logic                 empty;

  reg_sel_e             sel;
  logic                 ctrl_wr;
  logic                 flush;
  logic                 pop_req;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  assign sel          = decode_addr(addr);
  assign ctrl_wr      = wen && (sel == SEL_CTRL);
  assign flush        = ctrl_wr && wdata[1];
  assign pop_req      = ren && (sel == SEL_TS_LO);
  assign pop          = pop_req && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push         = trig_i && enable && (!full || pop) && !flush;
  assign drop         = trig_i && enable && full && !pop && !flush;
  assign {head_ts, head_phase} = head;
  assign unused_wdata = &{1'b0, wdata[31:2]};

  red_pitaya_trigger_log_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .wr_data   ({ts_i, phase_i}),
    .head      (head),
    .count     (count),
    .count_nxt (count_nxt),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    rd_mux = '0;
    case (sel)
      SEL_CTRL:   rd_mux = {31'd0, enable};
      SEL_STATUS: rd_mux = {ovf_cnt, underflow, 6'd0, 9'(count)};
      SEL_TS_LO:  rd_mux = pop ? head_ts[31:0] : 32'd0;
      SEL_TS_HI:  rd_mux = 32'(shadow_hi);
      SEL_PHASE:  rd_mux = 32'(shadow_phase);
      SEL_DEPTH:  rd_mux = 32'(2 ** DEPTH_LOG2);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable       <= 1'b0;
      underflow    <= 1'b0;
      ovf_cnt      <= '0;
      shadow_hi    <= '0;
      shadow_phase <= '0;
      ack          <= 1'b0;
      rdata        <= '0;
      not_empty_o  <= 1'b0;
    end else begin
      ack         <= wen | ren;
      rdata       <= ren ? rd_mux : 32'd0;
      not_empty_o <= (count_nxt != '0);
      if (ctrl_wr)
        enable <= wdata[0];
      if (flush) begin
        ovf_cnt   <= '0;
        underflow <= 1'b0;
      end else begin
        if (drop && (ovf_cnt != 16'hFFFF))
          ovf_cnt <= ovf_cnt + 16'd1;
        if (pop_req && empty)
          underflow <= 1'b1;
      end
      // Shadows latch together with the TS_LO pop so TS_HI/PHASE stay coherent.
      if (pop) begin
        shadow_hi    <= head_ts[TSBITS-1:32];
        shadow_phase <= head_phase;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_trigger_log.sv
// Self-checking bench for red_pitaya_trigger_log: table-driven register reads
// plus hand-written sequences for overflow, underflow, flush and mid-drain reset.
module tb_red_pitaya_trigger_log;
  import red_pitaya_trigger_log_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int TSBITS     = 64;
  localparam int PHASEBITS  = 14;

  logic                 clk_i   = 1'b0;
  logic                 rst_i   = 1'b1;
  logic                 trig_i  = 1'b0;
  logic [TSBITS-1:0]    ts_i    = '0;
  logic [PHASEBITS-1:0] phase_i = '0;
  logic [15:0]          addr    = '0;
  logic                 wen     = 1'b0;
  logic                 ren     = 1'b0;
  logic [31:0]          wdata   = '0;
  logic                 not_empty_o;
  logic                 ack;
  logic [31:0]          rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t reset_tbl [7];

  red_pitaya_trigger_log #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .TSBITS     (TSBITS),
    .PHASEBITS  (PHASEBITS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .trig_i      (trig_i),
    .ts_i        (ts_i),
    .phase_i     (phase_i),
    .not_empty_o (not_empty_o),
    .addr        (addr),
    .wen         (wen),
    .ren         (ren),
    .ack         (ack),
    .rdata       (rdata),
    .wdata       (wdata)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] status(input logic [15:0] ovf, input logic uf, input int cnt);
    logic [8:0] c;
    c = 9'(cnt);
    return {ovf, uf, 6'd0, c};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Drives one bus/trigger cycle; returns at posedge+1 with inputs idled.
  task automatic applyStimulus(input logic t, input logic [TSBITS-1:0] ts, input logic [PHASEBITS-1:0] ph,
                               input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
    trig_i = t; ts_i = ts; phase_i = ph; ren = r; wen = w; addr = a; wdata = d;
    @(posedge clk_i); #1;
    trig_i = 1'b0; ren = 1'b0; wen = 1'b0;
  endtask

  task automatic collectRead();
    int          waited;
    logic [31:0] e;
    string       n;
    waited = 0;
    while (ack !== 1'b1 && waited < 4) begin
      @(posedge clk_i); #1;
      waited++;
    end
    n = name_q.pop_front();
    e = exp_q.pop_front();
    if (ack !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: ack got %b want 1", n, ack);
    end else begin
      checkOutput(n, rdata, e);
    end
  endtask

  task automatic expectRead(input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic busRead(input logic [15:0] a, input logic [31:0] e, input string n);
    expectRead(e, n);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, a, 32'd0);
    collectRead();
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [31:0] d);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, a, d);
  endtask

  task automatic pulseTrig(input logic [TSBITS-1:0] ts, input logic [PHASEBITS-1:0] ph);
    applyStimulus(1'b1, ts, ph, 1'b0, 1'b0, 16'd0, 32'd0);
  endtask

  initial begin
    reset_tbl[0] = '{addr: ADDR_STATUS, exp: 32'h0000_0000};
    reset_tbl[1] = '{addr: ADDR_DEPTH,  exp: 32'd16};
    reset_tbl[2] = '{addr: ADDR_CTRL,   exp: 32'h0000_0000};
    reset_tbl[3] = '{addr: ADDR_TS_HI,  exp: 32'h0000_0000};
    reset_tbl[4] = '{addr: ADDR_PHASE,  exp: 32'h0000_0000};
    reset_tbl[5] = '{addr: 16'h0018,    exp: 32'h0000_0000};
    reset_tbl[6] = '{addr: 16'h0100,    exp: 32'h0000_0000};

    #3;
    checkOutput("rst_ack",       {31'd0, ack},         32'd0);
    checkOutput("rst_rdata",     rdata,                32'd0);
    checkOutput("rst_not_empty", {31'd0, not_empty_o}, 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++)
      busRead(reset_tbl[i].addr, reset_tbl[i].exp, $sformatf("reset_tbl[%0d]", i));
    checkOutput("idle_not_empty", {31'd0, not_empty_o}, 32'd0);

    // Single capture and coherent readback
    busWrite(ADDR_CTRL, 32'd1);
    busRead(ADDR_CTRL, 32'd1, "ctrl_enable");
    pulseTrig(64'h0000_0001_0000_00AA, 14'h1F00);
    checkOutput("one_not_empty", {31'd0, not_empty_o}, 32'd1);
    busRead(ADDR_STATUS, status(16'd0, 1'b0, 1), "one_status");
    busRead(ADDR_TS_LO,  32'h0000_00AA, "one_ts_lo");
    busRead(ADDR_TS_HI,  32'h0000_0001, "one_ts_hi");
    busRead(ADDR_PHASE,  32'h0000_1F00, "one_phase");
    busRead(ADDR_STATUS, status(16'd0, 1'b0, 0), "one_status_after");
    checkOutput("one_empty_flag", {31'd0, not_empty_o}, 32'd0);

    // 18 triggers into a 16-deep FIFO, then drain in order
    for (int i = 1; i <= 18; i++)
      pulseTrig({32'(i), 32'hC000_0000 | 32'(i)}, 14'(16'h100 + i));
    busRead(ADDR_STATUS, status(16'd2, 1'b0, 16), "ovf_status");
    for (int i = 1; i <= 16; i++) begin
      busRead(ADDR_TS_LO, 32'hC000_0000 | 32'(i), $sformatf("drain_lo[%0d]", i));
      busRead(ADDR_TS_HI, 32'(i),                 $sformatf("drain_hi[%0d]", i));
      busRead(ADDR_PHASE, 32'(16'h100 + i),       $sformatf("drain_ph[%0d]", i));
    end
    busRead(ADDR_STATUS, 32'h0002_0000, "drained_status");

    // Empty pop: zero data, sticky underflow, shadows untouched
    busRead(ADDR_TS_LO,  32'd0,                      "empty_pop");
    busRead(ADDR_STATUS, status(16'd2, 1'b1, 0),    "underflow_status");
    busRead(ADDR_TS_HI,  32'd16,                     "shadow_hi_kept");
    busRead(ADDR_PHASE,  32'h0000_0110,              "shadow_ph_kept");

    // Flush with a trigger in the same cycle; enable stays as written
    pulseTrig(64'h1, 14'h1);
    pulseTrig(64'h2, 14'h2);
    applyStimulus(1'b1, 64'h3, 14'h3, 1'b0, 1'b1, ADDR_CTRL, 32'd3);
    busRead(ADDR_STATUS, 32'd0, "flush_status");
    busRead(ADDR_CTRL,   32'd1, "flush_ctrl");
    checkOutput("flush_not_empty", {31'd0, not_empty_o}, 32'd0);

    // Full FIFO: trigger and TS_LO pop in one cycle
    for (int i = 1; i <= 16; i++)
      pulseTrig({32'hAB, 32'hD000_0000 | 32'(i)}, 14'(i));
    busRead(ADDR_STATUS, status(16'd0, 1'b0, 16), "full_status");
    expectRead(32'hD000_0001, "simul_head");
    applyStimulus(1'b1, {32'h5A5A, 32'hDEAD_BEEF}, 14'h3FFF, 1'b1, 1'b0, ADDR_TS_LO, 32'd0);
    collectRead();
    busRead(ADDR_STATUS, status(16'd0, 1'b0, 16), "simul_status");
    for (int i = 2; i <= 16; i++)
      busRead(ADDR_TS_LO, 32'hD000_0000 | 32'(i), $sformatf("simul_drain[%0d]", i));
    busRead(ADDR_TS_LO,  32'hDEAD_BEEF, "simul_last_lo");
    busRead(ADDR_TS_HI,  32'h0000_5A5A, "simul_last_hi");
    busRead(ADDR_PHASE,  32'h0000_3FFF, "simul_last_ph");
    busRead(ADDR_STATUS, 32'd0,         "simul_final_status");

    // Read and write of CTRL together: read sees pre-write value
    expectRead(32'd1, "rw_same_pre");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, ADDR_CTRL, 32'd0);
    collectRead();
    busRead(ADDR_CTRL, 32'd0, "rw_same_post");
    busWrite(ADDR_CTRL, 32'd1);

    // Asynchronous reset mid-drain with five entries left
    for (int i = 1; i <= 8; i++)
      pulseTrig({32'h0, 32'hE000_0000 | 32'(i)}, 14'(i));
    busRead(ADDR_TS_LO, 32'hE000_0001, "pre_rst_pop1");
    busRead(ADDR_TS_LO, 32'hE000_0002, "pre_rst_pop2");
    busRead(ADDR_TS_LO, 32'hE000_0003, "pre_rst_pop3");
    checkOutput("pre_rst_not_empty", {31'd0, not_empty_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_ack",       {31'd0, ack},         32'd0);
    checkOutput("async_rst_rdata",     rdata,                32'd0);
    checkOutput("async_rst_not_empty", {31'd0, not_empty_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    busRead(ADDR_STATUS, 32'd0, "post_rst_status");
    busRead(ADDR_CTRL,   32'd0, "post_rst_ctrl");

    // Disabled: triggers are neither stored nor counted as overflow
    pulseTrig(64'h77, 14'h7);
    busRead(ADDR_STATUS, 32'd0, "disabled_status");
    checkOutput("disabled_not_empty", {31'd0, not_empty_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
